bcd_digit_sequencer: RTL and testbench
======================================

// Module: bcd_digit_sequencer
// PURPOSE
//  4-digit BCD event counter/sequencer that drives the units/tens/hundreds/
//  thousands digit nibbles consumed by the 4-bit input PIO slaves.
//  Nios II controls it through a 4-register Avalon-MM slave: run/stop, clear,
//  preload, tick rate, and wrap status. A prescaler generates the count tick.
// PARAMETERS
//  DIV_W     26          width of prescaler / DIV register
//  DIV_RST   50000000    DIV reset value (1 Hz tick at 50 MHz clk)
// PORTS
//  clk              in   1   system clock, all logic on rising edge
//  reset            in   1   synchronous, active-high reset
//  address          in   2   Avalon register select
//  write            in   1   Avalon write strobe
//  writedata        in   32  Avalon write data
//  readdata         out  32  Avalon read data, registered
//  digit_units      out  4   BCD units digit
//  digit_tens       out  4   BCD tens digit
//  digit_hundreds   out  4   BCD hundreds digit
//  digit_thousands  out  4   BCD thousands digit
//  running          out  1   1 while in RUN state
//  wrap_pulse       out  1   1-cycle pulse on 9999->0000 (or 0000->9999 down)
// BEHAVIOUR
//  Registers (address):
//   0 CTRL   W: b0 run, b1 clear (self-clearing, not stored), b2 dir (macro)
//            R: {29'b0, dir, 1'b0, run}
//   1 COUNT  R: {16'b0, thousands, hundreds, tens, units}; W: preload [15:0]
//            any preload nibble >9 is loaded as 9
//   2 DIV    R/W: tick period in clk cycles, [DIV_W-1:0]; 0 behaves as 1
//   3 STATUS R: b0 wrapped (sticky); W: b0=1 clears it
//  Reset: all digits 0, run=0, dir=0, DIV=DIV_RST, prescaler=0, wrapped=0,
//   readdata=0, running=0, wrap_pulse=0.
//  FSM: STOP <-> RUN, state == CTRL.run. STOP: prescaler held at 0, no ticks.
//   RUN: prescaler counts 0..DIV-1; tick asserted in cycle prescaler==DIV-1,
//   prescaler returns to 0. First tick DIV cycles after run write.
//  Tick: units +1 (BCD); 9->0 carries into next digit; cascade through all 4
//   digits in the same cycle. 9999->0000 sets wrapped and pulses wrap_pulse
//   in the cycle digits become 0000.
//  Digit outputs update in the cycle after the tick edge (registered).
//  Write to DIV resets prescaler to 0; write to CTRL.run 0->1 resets it too.
//  Priority in one cycle: clear > COUNT preload > tick. Clear zeroes digits
//   and prescaler, does not change run or wrapped. Tick coinciding with
//   clear/preload is dropped.
//  wrapped set and STATUS clear in the same cycle: set wins.
//  readdata: registered mux of address every clock (no read strobe),
//   1-cycle latency, unused bits 0; unmapped bits read 0.
//  Reset asserted mid-run: all state returns to reset values next edge.
// CONFIGURATION
//  BCD_UPDOWN_EN defined: CTRL.b2 dir stored; dir=1 counts down (0->9 borrow
//   cascade), 0000->9999 sets wrapped and pulses wrap_pulse.
//  BCD_UPDOWN_EN undefined: up-count only; b2 ignored on write, reads 0.
// TESTING
//  1 reset; read addr 2 -> 0x02FAF080; addr 1 -> 0; running=0.
//  2 DIV=3, CTRL=1: digits 0001 after 3 cycles, 0002 after 6; running=1.
//  3 preload 0x0999, DIV=1, run: next tick -> 0x1000; preload 0x9999 -> tick
//    -> 0x0000, wrap_pulse 1 cycle, STATUS=1; write STATUS=1 -> 0.
//  4 preload 0x0A5F -> COUNT reads 0x0959; CTRL=3 while running -> 0x0000,
//    run stays 1; CTRL=0 -> digits frozen over 100 cycles.
//  5 preload write on tick cycle -> preload value wins, no increment.
//  6 BCD_UPDOWN_EN: CTRL=5, COUNT=0x0000, DIV=1 -> 0x9999 + wrap_pulse, then
//    0x9998; without macro same writes count up to 0x0001.

Source files
------------

// File: rtl/bcd_digit_sequencer.sv
// 4-digit BCD event counter with prescaled tick and a 4-register Avalon-MM slave.
// Optional up/down counting is enabled by defining BCD_UPDOWN_EN.
module bcd_digit_sequencer #(
  parameter int               DIV_W   = 26,
  parameter logic [DIV_W-1:0] DIV_RST = DIV_W'(50_000_000)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [3:0]  digit_units,
  output logic [3:0]  digit_tens,
  output logic [3:0]  digit_hundreds,
  output logic [3:0]  digit_thousands,
  output logic        running,
  output logic        wrap_pulse
);

  typedef enum logic {STOP, RUN} state_t;

  state_t             state;
  logic               dir;
  logic [DIV_W-1:0]   div;
  logic [DIV_W-1:0]   presc;
  logic [15:0]        count;
  logic               wrapped;

  logic               wr_ctrl, wr_cnt, wr_div, wr_stat;
  logic               clr, run_rise, tick;
  logic [DIV_W-1:0]   last;
  logic [16:0]        nxt;
  logic               unused_wd;

  // One BCD step with carry/borrow cascade; bit 16 flags a full wrap.
  function automatic logic [16:0] bcd_step(input logic [15:0] v, input logic down);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (down) begin
          if (v[i*4 +: 4] == 4'd0) r[i*4 +: 4] = 4'd9;
          else begin
            r[i*4 +: 4] = v[i*4 +: 4] - 4'd1;
            c = 1'b0;
          end
        end else begin
          if (v[i*4 +: 4] >= 4'd9) r[i*4 +: 4] = 4'd0;
          else begin
            r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
            c = 1'b0;
          end
        end
      end
    end
    return {c, r};
  endfunction

  function automatic logic [15:0] bcd_sat(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    for (int i = 0; i < 4; i++)
      if (v[i*4 +: 4] > 4'd9) r[i*4 +: 4] = 4'd9;
    return r;
  endfunction

  assign wr_ctrl  = write && (address == 2'd0);
  assign wr_cnt   = write && (address == 2'd1);
  assign wr_div   = write && (address == 2'd2);
  assign wr_stat  = write && (address == 2'd3);
  assign clr      = wr_ctrl && writedata[1];
  assign run_rise = wr_ctrl && writedata[0] && (state == STOP);

  // A DIV of 0 behaves like 1: tick every cycle.
  assign last = (div == '0) ? '0 : div - DIV_W'(1);
  assign tick = (state == RUN) && (presc == last);
  assign nxt  = bcd_step(count, dir);

  assign unused_wd = ^writedata;

`ifdef BCD_UPDOWN_EN
  always_ff @(posedge clk) begin
    if (reset)        dir <= 1'b0;
    else if (wr_ctrl) dir <= writedata[2];
  end
`else
  assign dir = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= STOP;
      div        <= DIV_RST;
      presc      <= '0;
      count      <= '0;
      wrapped    <= 1'b0;
      wrap_pulse <= 1'b0;
      readdata   <= '0;
    end else begin
      wrap_pulse <= 1'b0;

      if (wr_ctrl) state <= writedata[0] ? RUN : STOP;
      if (wr_div)  div   <= writedata[DIV_W-1:0];

      if (clr || wr_div || run_rise || tick || state == STOP) presc <= '0;
      else                                                    presc <= presc + DIV_W'(1);

      // Clear beats preload beats tick; a dropped tick cannot wrap.
      if (clr)          count <= '0;
      else if (wr_cnt)  count <= bcd_sat(writedata[15:0]);
      else if (tick) begin
        count      <= nxt[15:0];
        wrap_pulse <= nxt[16];
      end

      if (tick && !clr && !wr_cnt && nxt[16]) wrapped <= 1'b1;
      else if (wr_stat && writedata[0])      wrapped <= 1'b0;

      case (address)
        2'd0:    readdata <= {29'b0, dir, 1'b0, state == RUN};
        2'd1:    readdata <= {16'b0, count};
        2'd2:    readdata <= 32'(div);
        default: readdata <= {31'b0, wrapped};
      endcase
    end
  end

  assign running         = (state == RUN);
  assign digit_units     = count[3:0];
  assign digit_tens      = count[7:4];
  assign digit_hundreds  = count[11:8];
  assign digit_thousands = count[15:12];

endmodule

// File: tb/tb_bcd_digit_sequencer.sv
// Scoreboard bench for bcd_digit_sequencer: directed writes push expected
// register reads or {wrap_pulse, running, digits} snapshots, a monitor compares.
module tb_bcd_digit_sequencer;

  logic        clk;
  logic        reset;
  logic [1:0]  address;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [3:0]  digit_units, digit_tens, digit_hundreds, digit_thousands;
  logic        running, wrap_pulse;

  bcd_digit_sequencer dut (
    .clk(clk), .reset(reset), .address(address), .write(write),
    .writedata(writedata), .readdata(readdata),
    .digit_units(digit_units), .digit_tens(digit_tens),
    .digit_hundreds(digit_hundreds), .digit_thousands(digit_thousands),
    .running(running), .wrap_pulse(wrap_pulse)
  );

  typedef struct packed {
    logic        sel;   // 0: readdata, 1: {wrap_pulse, running, digits}
    logic [31:0] exp;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    total = 0;
  int    bad   = 0;
  logic  rd_req = 1'b0;
  logic  rd_vld = 1'b0;
  logic  fin_req = 1'b0;
  logic  fin_ack = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) rd_vld <= rd_req;

  always @(negedge clk) begin
    if (rd_vld) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL monitor: output presented with empty scoreboard");
      end else begin
        exp_t        e;
        string       nm;
        logic [31:0] act;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        act = e.sel ? {14'b0, wrap_pulse, running, digit_thousands, digit_hundreds,
                       digit_tens, digit_units} : readdata;
        if (act !== e.exp) begin
          bad++;
          $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, e.exp);
        end
      end
    end
    if (fin_req && !fin_ack) begin
      total++;
      if (exp_q.size() != 0) begin
        bad++;
        $display("FAIL drain: %0d expectations never checked, expected 0", exp_q.size());
      end
      fin_ack = 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address   = a;
    writedata = d;
    write     = 1'b1;
    step();
    write     = 1'b0;
  endtask

  task automatic chk(input logic sel, input logic [1:0] a, input logic [31:0] e,
                     input string nm);
    exp_t x;
    if (!sel) address = a;
    x.sel = sel;
    x.exp = e;
    exp_q.push_back(x);
    name_q.push_back(nm);
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
  endtask

  initial begin
    reset = 1'b1; address = 2'd0; write = 1'b0; writedata = '0;
    repeat (3) step();
    reset = 1'b0;

    // reset state
    chk(0, 2'd2, 32'h02FA_F080, "rst_div");
    chk(0, 2'd1, 32'h0, "rst_count");
    chk(1, 2'd0, 32'h0, "rst_outputs");
    chk(0, 2'd3, 32'h0, "rst_status");
    chk(0, 2'd0, 32'h0, "rst_ctrl");

    // DIV=3: first tick 3 cycles after run
    wr(2'd2, 32'd3);
    wr(2'd0, 32'd1);
    chk(1, 2'd0, 32'h1_0000, "div3_c1");
    chk(1, 2'd0, 32'h1_0000, "div3_c2");
    chk(1, 2'd0, 32'h1_0001, "div3_c3");
    chk(1, 2'd0, 32'h1_0001, "div3_c4");
    chk(1, 2'd0, 32'h1_0001, "div3_c5");
    chk(1, 2'd0, 32'h1_0002, "div3_c6");

    // carry cascade and wrap
    wr(2'd0, 32'd0);
    wr(2'd1, 32'h0999);
    wr(2'd2, 32'd1);
    wr(2'd0, 32'd1);
    chk(1, 2'd0, 32'h1_1000, "carry_0999");
    wr(2'd0, 32'd0);
    wr(2'd1, 32'h9999);
    wr(2'd0, 32'd1);
    chk(1, 2'd0, 32'h3_0000, "wrap_9999");
    chk(1, 2'd0, 32'h1_0001, "wrap_pulse_1cyc");
    wr(2'd0, 32'd0);
    chk(0, 2'd3, 32'h1, "status_sticky");
    wr(2'd3, 32'd1);
    chk(0, 2'd3, 32'h0, "status_clear");

    // saturating preload, clear while running, freeze when stopped
    wr(2'd1, 32'h0A5F);
    chk(0, 2'd1, 32'h0959, "preload_sat");
    wr(2'd2, 32'd100);
    wr(2'd0, 32'd1);
    wr(2'd0, 32'd3);
    chk(1, 2'd0, 32'h1_0000, "clear_running");
    chk(0, 2'd0, 32'h1, "ctrl_run_kept");
    wr(2'd0, 32'd0);
    wr(2'd2, 32'd1);
    wr(2'd1, 32'h1234);
    repeat (100) step();
    chk(1, 2'd0, 32'h0_1234, "frozen_stop");

    // preload on a tick cycle drops the tick
    wr(2'd1, 32'h0);
    wr(2'd0, 32'd1);
    wr(2'd1, 32'h0500);
    chk(1, 2'd0, 32'h1_0501, "preload_on_tick");
    wr(2'd0, 32'd0);
    chk(1, 2'd0, 32'h0_0502, "stop_after_tick");

    // DIV=0 ticks every cycle
    wr(2'd2, 32'd0);
    wr(2'd1, 32'h0);
    wr(2'd0, 32'd1);
    chk(1, 2'd0, 32'h1_0001, "div0_t1");
    chk(1, 2'd0, 32'h1_0002, "div0_t2");
    wr(2'd0, 32'd0);
    chk(0, 2'd2, 32'h0, "div0_read");

    // wrap set beats STATUS clear in the same cycle
    wr(2'd2, 32'd1);
    wr(2'd1, 32'h9999);
    wr(2'd0, 32'd1);
    wr(2'd3, 32'd1);
    wr(2'd0, 32'd0);
    chk(0, 2'd3, 32'h1, "set_beats_clear");
    wr(2'd3, 32'd1);

    // direction bit
    wr(2'd1, 32'h0);
    wr(2'd0, 32'd5);
`ifdef BCD_UPDOWN_EN
    chk(1, 2'd0, 32'h3_9999, "down_wrap");
    chk(1, 2'd0, 32'h1_9998, "down_next");
    chk(0, 2'd0, 32'h5, "ctrl_dir");
`else
    chk(1, 2'd0, 32'h1_0001, "dir_ignored_t1");
    chk(1, 2'd0, 32'h1_0002, "dir_ignored_t2");
    chk(0, 2'd0, 32'h1, "ctrl_no_dir");
`endif

    // reset mid-run
    reset = 1'b1;
    chk(1, 2'd0, 32'h0, "midrun_reset");
    reset = 1'b0;
    chk(0, 2'd2, 32'h02FA_F080, "midrun_div");
    chk(0, 2'd0, 32'h0, "midrun_ctrl");

    fin_req = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    if (!fin_ack) begin
      bad++;
      total++;
      $display("FAIL drain_timeout: ack=%0d expected 1", fin_ack);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
